// File: rtl/regfile_wb_queue_pkg.sv
// Shared register-file write-back types and constants.
package regfile_wb_queue_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned REG_DW = 32;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wb_entry_t;

  typedef struct packed {
    logic              hit;
    logic [REG_DW-1:0] data;
  } wb_lookup_t;

endpackage

// File: rtl/regfile_wb_queue_if.sv
// Valid/ready write-request channel from a result producer to the write-back queue.
interface regfile_wb_queue_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
);
  logic          valid;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          ready;

  modport master (output valid, output addr, output data, input ready);
  modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/regfile_wb_queue_fifo.sv
// Dual-push / single-pop circular buffer; exposes every entry for the forwarding search.
module regfile_wb_queue_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push0,
  input  logic [AW-1:0]            push0_addr,
  input  logic [DW-1:0]            push0_data,
  input  logic                     push1,
  input  logic [AW-1:0]            push1_addr,
  input  logic [DW-1:0]            push1_data,
  input  logic                     pop,
  output logic [AW-1:0]            ent_addr [DEPTH],
  output logic [DW-1:0]            ent_data [DEPTH],
  output logic [DEPTH-1:0]         ent_vld,
  output logic [$clog2(DEPTH)-1:0] head_idx,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d, wr_idx1;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] vld_q, vld_d;

  // push1 lands behind push0 when both fire, otherwise it takes the write pointer slot
  always_comb begin
    wr_idx1 = wptr_q + PW'(push0);
    wptr_d  = wptr_q + PW'(push0) + PW'(push1);
    rptr_d  = rptr_q + PW'(pop);
    count_d = count_q + CW'(push0) + CW'(push1) - CW'(pop);
    vld_d   = vld_q;
    if (pop)   vld_d[rptr_q]  = 1'b0;
    if (push0) vld_d[wptr_q]  = 1'b1;
    if (push1) vld_d[wr_idx1] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      vld_q   <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push0) begin
      ent_addr[wptr_q] <= push0_addr;
      ent_data[wptr_q] <= push0_data;
    end
    if (push1) begin
      ent_addr[wr_idx1] <= push1_addr;
      ent_data[wr_idx1] <= push1_data;
    end
  end

  assign ent_vld  = vld_q;
  assign head_idx = rptr_q;
  assign count    = count_q;

endmodule

// File: rtl/regfile_wb_queue.sv
// Register-file write-back queue: merges producers A and B, drains one write per cycle,
// and forwards the youngest uncommitted value for two decode-stage queries.
module regfile_wb_queue
  import regfile_wb_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = REG_AW,
  parameter int unsigned DW    = REG_DW
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_wb_queue_if.slave      a,
  regfile_wb_queue_if.slave      b,
  output logic                   rf_wr,
  output logic [AW-1:0]          rf_addr,
  output logic [DW-1:0]          rf_data,
  input  logic [AW-1:0]          q1_addr,
  input  logic [AW-1:0]          q2_addr,
  output logic                   q1_hit,
  output logic                   q2_hit,
  output logic [DW-1:0]          q1_data,
  output logic [DW-1:0]          q2_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [CW-1:0]    cnt;
  logic [PW-1:0]    head_idx;
  logic [AW-1:0]    ent_addr [DEPTH];
  logic [DW-1:0]    ent_data [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic             a_rdy, b_rdy, push_a, push_b, pop;

  // Ready looks only at registered occupancy; B needs room for A landing ahead of it
  assign a_rdy   = cnt < CW'(DEPTH);
  assign b_rdy   = cnt < CW'(DEPTH - 1);
  assign a.ready = a_rdy;
  assign b.ready = b_rdy;

  // Writes to r0 complete the handshake but are never queued
  assign push_a = a.valid & a_rdy & (a.addr != '0);
  assign push_b = b.valid & b_rdy & (b.addr != '0);
  assign pop    = cnt != '0;

  regfile_wb_queue_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push0      (push_a),
    .push0_addr (a.addr),
    .push0_data (a.data),
    .push1      (push_b),
    .push1_addr (b.addr),
    .push1_data (b.data),
    .pop        (pop),
    .ent_addr   (ent_addr),
    .ent_data   (ent_data),
    .ent_vld    (ent_vld),
    .head_idx   (head_idx),
    .count      (cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_wr   <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
    end else begin
      rf_wr <= pop;
      if (pop) begin
        rf_addr <= ent_addr[head_idx];
        rf_data <= ent_data[head_idx];
      end
    end
  end

  logic [AW-1:0] q_addr [2];
  assign q_addr[0] = q1_addr;
  assign q_addr[1] = q2_addr;

  for (genvar g = 0; g < 2; g++) begin : g_lookup
    logic          hit;
    logic [DW-1:0] data;

    // Walk oldest to youngest so a later match overrides; output register is oldest of all
    always_comb begin
      logic [PW-1:0] idx;
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      if (rf_wr && rf_addr == q_addr[g]) begin
        hit  = 1'b1;
        data = rf_data;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = head_idx + PW'(i);
        if (ent_vld[idx] && ent_addr[idx] == q_addr[g]) begin
          hit  = 1'b1;
          data = ent_data[idx];
        end
      end
      if (q_addr[g] == '0) begin
        hit  = 1'b0;
        data = '0;
      end
    end
  end

  assign q1_hit  = g_lookup[0].hit;
  assign q1_data = g_lookup[0].data;
  assign q2_hit  = g_lookup[1].hit;
  assign q2_data = g_lookup[1].data;

  assign count = cnt;
  assign busy  = (cnt != '0) || rf_wr;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Scoreboard bench for regfile_wb_queue: a queue-level reference model predicts occupancy,
// ready, forwarding and the order of register-file commits.
module tb_regfile_wb_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rf_wr;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic [AW-1:0] q1_addr = '0, q2_addr = '0;
  logic          q1_hit, q2_hit;
  logic [DW-1:0] q1_data, q2_data;
  logic [2:0]    count;
  logic          busy;

  always #5 clk = ~clk;

  regfile_wb_queue_if #(.AW(AW), .DW(DW)) a_if ();
  regfile_wb_queue_if #(.AW(AW), .DW(DW)) b_if ();

  regfile_wb_queue #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .a       (a_if),
    .b       (b_if),
    .rf_wr   (rf_wr),
    .rf_addr (rf_addr),
    .rf_data (rf_data),
    .q1_addr (q1_addr),
    .q2_addr (q2_addr),
    .q1_hit  (q1_hit),
    .q2_hit  (q2_hit),
    .q1_data (q1_data),
    .q2_data (q2_data),
    .count   (count),
    .busy    (busy)
  );

  int   errors = 0;
  int   checks = 0;
  ent_t mq[$];    // model: entries waiting in the queue, oldest first
  ent_t sb_q[$];  // scoreboard: accepted writes not yet seen on the rf port
  logic out_v = 1'b0;
  ent_t out_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Youngest pending write to q, then the output register; r0 never hits.
  task automatic model_lookup(input logic [AW-1:0] q, output logic hit, output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (q != 0) begin
      for (int i = mq.size() - 1; i >= 0 && !hit; i--) begin
        if (mq[i].addr == q) begin
          hit = 1'b1;
          d   = mq[i].data;
        end
      end
      if (!hit && out_v && out_e.addr == q) begin
        hit = 1'b1;
        d   = out_e.data;
      end
    end
  endtask

  task automatic step(input logic rst,
                      input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                      input logic [AW-1:0] q1, input logic [AW-1:0] q2,
                      output logic acc_a, output logic acc_b);
    logic          h;
    logic [DW-1:0] d;
    logic          exp_ar, exp_br;
    exp_ar     = mq.size() <= DEPTH - 1;
    exp_br     = mq.size() <= DEPTH - 2;
    reset      = rst;
    a_if.valid = av;
    a_if.addr  = aa;
    a_if.data  = ad;
    b_if.valid = bv;
    b_if.addr  = ba;
    b_if.data  = bd;
    q1_addr    = q1;
    q2_addr    = q2;
    acc_a      = av && exp_ar && !rst;
    acc_b      = bv && exp_br && !rst;
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      sb_q.delete();
      out_v = 1'b0;
    end else begin
      if (mq.size() > 0) begin
        out_e = mq.pop_front();
        out_v = 1'b1;
      end else begin
        out_v = 1'b0;
      end
      if (acc_a && aa != 0) begin
        mq.push_back('{addr: aa, data: ad});
        sb_q.push_back('{addr: aa, data: ad});
      end
      if (acc_b && ba != 0) begin
        mq.push_back('{addr: ba, data: bd});
        sb_q.push_back('{addr: ba, data: bd});
      end
    end
    @(negedge clk);
    check("count", 64'(count), 64'(mq.size()));
    check("rf_wr", 64'(rf_wr), 64'(out_v));
    check("busy", 64'(busy), 64'(mq.size() != 0 || out_v));
    check("a_ready", 64'(a_if.ready), 64'(mq.size() <= DEPTH - 1));
    check("b_ready", 64'(b_if.ready), 64'(mq.size() <= DEPTH - 2));
    model_lookup(q1, h, d);
    check("q1_hit", 64'(q1_hit), 64'(h));
    check("q1_data", 64'(q1_data), 64'(d));
    model_lookup(q2, h, d);
    check("q2_hit", 64'(q2_hit), 64'(h));
    check("q2_data", 64'(q2_data), 64'(d));
  endtask

  task automatic idle(input logic [AW-1:0] q1, input logic [AW-1:0] q2);
    logic x, y;
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, q1, q2, x, y);
  endtask

  // Every write the DUT presents must be the oldest outstanding accepted write.
  always @(negedge clk) begin : monitor
    ent_t e;
    if (rf_wr === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL rf_unexpected: got write r%0d=%0h expected none at %0t",
                 rf_addr, rf_data, $time);
      end else begin
        e = sb_q.pop_front();
        if (rf_addr !== e.addr || rf_data !== e.data) begin
          errors++;
          $display("FAIL rf_commit: got r%0d=%0h expected r%0d=%0h at %0t",
                   rf_addr, rf_data, e.addr, e.data, $time);
        end
      end
    end
  end

  initial begin
    logic          x, y, ra_v, rb_v, pa, pb;
    logic [AW-1:0] ra_a, rb_a;
    logic [DW-1:0] ra_d, rb_d;

    a_if.valid = 1'b0;
    a_if.addr  = '0;
    a_if.data  = '0;
    b_if.valid = 1'b0;
    b_if.addr  = '0;
    b_if.data  = '0;

    // Reset then a single write through the pipeline
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 5'd5, 5'd0, x, y);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 5'd5, 5'd0, x, y);
    step(1'b0, 1'b1, 5'd5, 32'h1234_5678, 1'b0, '0, '0, 5'd5, 5'd0, x, y);
    idle(5'd5, 5'd0);
    check("single_rf_wr", 64'(rf_wr), 64'd1);
    check("single_rf_addr", 64'(rf_addr), 64'd5);
    check("single_rf_data", 64'(rf_data), 64'h1234_5678);
    idle(5'd5, 5'd0);
    check("single_busy_drop", 64'(busy), 64'd0);

    // Same-cycle A and B to r3: B is younger
    step(1'b0, 1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB, 5'd3, 5'd0, x, y);
    check("dual_fwd_hit", 64'(q1_hit), 64'd1);
    check("dual_fwd_data", 64'(q1_data), 64'hB);
    idle(5'd3, 5'd0);
    idle(5'd3, 5'd0);
    idle(5'd3, 5'd0);

    // r0 writes are accepted and dropped
    step(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, '0, '0, 5'd0, 5'd0, x, y);
    check("r0_accepted", 64'(x), 64'd1);
    check("r0_count", 64'(count), 64'd0);
    idle(5'd0, 5'd0);
    check("r0_no_write", 64'(rf_wr), 64'd0);

    // Forwarding from the output register only
    step(1'b0, 1'b1, 5'd7, 32'h55, 1'b0, '0, '0, 5'd7, 5'd0, x, y);
    idle(5'd7, 5'd0);
    check("outreg_hit", 64'(q1_hit), 64'd1);
    check("outreg_data", 64'(q1_data), 64'h55);
    idle(5'd7, 5'd0);
    check("outreg_gone", 64'(q1_hit), 64'd0);

    // Fill to three entries: A still ready, B held off
    step(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 5'd1, 5'd2, x, y);
    step(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 5'd3, 5'd4, x, y);
    check("fill_count", 64'(count), 64'd3);
    check("fill_a_ready", 64'(a_if.ready), 64'd1);
    check("fill_b_ready", 64'(b_if.ready), 64'd0);

    // Reset mid-drain discards everything still pending
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 5'd3, 5'd4, x, y);
    check("rst_rf_wr", 64'(rf_wr), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_q1_hit", 64'(q1_hit), 64'd0);
    idle(5'd2, 5'd3);
    idle(5'd4, 5'd1);

    // Random traffic; a refused request is held stable until it transfers
    ra_v = 1'b0; rb_v = 1'b0; pa = 1'b1; pb = 1'b1;
    ra_a = '0; rb_a = '0; ra_d = '0; rb_d = '0;
    for (int c = 0; c < 200; c++) begin
      if (!ra_v || pa) begin
        ra_v = ($urandom_range(0, 9) < 6);
        ra_a = AW'($urandom_range(0, 7));
        ra_d = $urandom;
      end
      if (!rb_v || pb) begin
        rb_v = ($urandom_range(0, 9) < 5);
        rb_a = AW'($urandom_range(0, 7));
        rb_d = $urandom;
      end
      step(1'b0, ra_v, ra_a, ra_d, rb_v, rb_a, rb_d,
           AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), pa, pb);
    end
    for (int c = 0; c < 8; c++) idle('0, '0);
    check("drained", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Write-back side of the CPU register file.
- Collects register write requests from two producers: A (ALU/branch-link results) and B (load/multiplier results).
- Buffers them in a small in-order queue and drains one write per cycle onto the register file's single write port (wr / addr / data).
- Gives the decode stage a forwarding lookup over every write that is not yet committed, so operand reads never see stale data.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- AW, 5, register address width.
- DW, 32, register data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- a_valid  in  1  producer A write request.
- a_addr  in  AW  destination register for A.
- a_data  in  DW  write data for A.
- a_ready  out  1  A may enqueue this cycle.
- b_valid  in  1  producer B write request.
- b_addr  in  AW  destination register for B.
- b_data  in  DW  write data for B.
- b_ready  out  1  B may enqueue this cycle.
- rf_wr  out  1  register-file write enable (registered).
- rf_addr  out  AW  register-file write address (registered).
- rf_data  out  DW  register-file write data (registered).
- q1_addr, q2_addr  in  AW  forwarding query addresses.
- q1_hit, q2_hit  out  1  query matches a pending write (combinational).
- q1_data, q2_data  out  DW  youngest pending data for the query (combinational).
- count  out  clog2(DEPTH)+1  occupied queue entries.
- busy  out  1  count != 0 or rf_wr.

Behaviour:
- Reset (sync, high): queue emptied, pointers 0, count=0. rf_wr=0, rf_addr=0, rf_data=0. Lookup hit outputs are 0. Pending writes are discarded. The same applies when reset is asserted mid-drain.
- Ready (depends only on registered count, never on valid):
  - a_ready = (DEPTH-count >= 1).
  - b_ready = (DEPTH-count >= 2).
  - A same-cycle pop does not free a slot for that cycle's ready.
- Handshake:
  - A transfer occurs on an edge where valid & ready.
  - A producer holds addr/data stable while valid & !ready.
- Enqueue order: when A and B both transfer in one cycle, A is older and is written at wptr, B at wptr+1. Pointers wrap modulo DEPTH.
- Address 0: a transfer with addr==0 is accepted (ready honoured) and dropped; it is not enqueued and count is unchanged.
- Drain: each edge with count!=0 pops the head into the output register, so rf_wr=1 with the head's addr/data for the following cycle. rf_wr=0 otherwise. One write per cycle maximum.
- Latency: a transfer accepted at edge k with an empty queue gives rf_wr=1 in the cycle after edge k+1. The register file commits it at edge k+2.
- Simultaneous push and pop: count_next = count + pushes - pop. A push of 2 into count=DEPTH-2 is legal; overflow is unreachable by the ready rules.
- Forwarding lookup for q1 and q2 independently:
  - Candidates are the valid queue entries plus the output register when rf_wr=1.
  - The youngest matching candidate wins: newest queue entry first, then older entries, and the output register last.
  - qN_addr==0 gives hit=0 and data=0.
  - No match gives hit=0 and data=0.
  - Same-cycle incoming A/B requests are not searched; the decode stage stalls on those.
- Ordering guarantee: writes to the same register reach rf in acceptance order, A before B within a cycle.

Decomposition:
- Shared package (cpu_pkg):
  - constants REG_AW=5 and REG_DW=32.
  - typedef wb_entry_t {addr[AW], data[DW]}.
  - typedef of the lookup result {hit, data}.
- One natural sub-module, wbq_fifo:
  - dual-push / single-pop circular buffer with per-entry valid bits;
  - exports its entries, valid bits and head index for the lookup logic.
- Youngest-match priority search and the output register stay in the top.

Test Plan:
- Reset, single write: after reset, count=0 and rf_wr=0. A writes r5=0x1234_5678 at edge 1. Required: rf_wr=1, rf_addr=5, rf_data=0x12345678 in the cycle after edge 2; count returns to 0 and busy drops after edge 3.
- Dual push ordering: A r3=0xA and B r3=0xB in the same cycle. Required: rf commits r3=0xA then r3=0xB on consecutive cycles. While both are pending, q1_addr=3 gives hit=1, data=0xB.
- Backpressure at full (DEPTH=4): hold the drain behind a B burst until count=3. Required: a_ready=1, b_ready=0; at count=4, a_ready=0. No entry is lost or duplicated, checked by a scoreboard over 200 random cycles.
- r0 handling: A writes r0=0xFFFF_FFFF. Required: the transfer is accepted, count stays 0, rf_wr never asserts. q2_addr=0 gives hit=0, data=0.
- Forwarding from the output register: r7=0x55 sits in the output register (rf_wr=1) with no queue entry for r7. Required: q1_addr=7 gives hit=1, data=0x55; after the commit edge, hit=0.
- Reset mid-drain: three entries queued, then reset asserted for one edge. Required: the next cycle shows rf_wr=0, count=0, all hits 0, and no write of the discarded data ever appears.
